uart_transmitter: RTL and testbench

- 8N1 UART transmitter; the transmit-side counterpart of the instruction-programming `uart_receiver`.
- Accepts bytes over a valid/ready handshake into a small FIFO and serialises them LSB-first on `tx_serial_o`.
- Bit period is set at runtime by `clks_per_bit_i`, with the same semantics as the receiver's `CLKS_PER_BIT`.
- Used for boot/programming acknowledgements and debug output back to the host.

---
 rtl/uart_transmitter.sv | 191 +++++++++++++++++++
 tb/tb_uart_transmitter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART transmitter with a small byte FIFO.
// Bytes are accepted over a valid/ready handshake and sent LSB-first on tx_serial_o.
// The bit period comes from clks_per_bit_i and is captured at the start of each frame.
// Optional macro UART_TX_PARITY_EN adds parity_odd_i and a parity bit before the stop bit.
`timescale 1ns/1ps
module uart_transmitter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [15:0]                 clks_per_bit_i,
    input  logic                        tx_valid_i,
    input  logic [7:0]                  tx_byte_i,
`ifdef UART_TX_PARITY_EN
    input  logic                        parity_odd_i,
`endif
    output logic                        tx_ready_o,
    output logic                        tx_serial_o,
    output logic                        tx_active_o,
    output logic                        tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic        w_full, w_empty, w_push, w_pop, w_load, w_last, w_tx_n;
    logic [7:0]  w_head;
    logic [15:0] w_eff_period;

    state_t      r_state, w_state_n;
    logic [15:0] r_cnt, w_cnt_n, r_period, w_period_n;
    logic [2:0]  r_idx, w_idx_n;
    logic [7:0]  r_shift, w_shift_n;
    logic        r_tx;
`ifdef UART_TX_PARITY_EN
    logic        r_par, w_par_n;
`endif

    // Pointers are one bit wider than the index: equal MSBs mean empty, differing MSBs mean full.
    assign w_empty      = (r_wptr == r_rptr);
    assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push       = tx_valid_i & ~w_full;
    assign w_head       = r_mem[r_rptr[AW-1:0]];
    assign tx_ready_o   = ~w_full;
    assign fifo_level_o = r_wptr - r_rptr;

    // Periods below 2 are clamped so every bit lasts at least two cycles.
    assign w_eff_period = (clks_per_bit_i < 16'd2) ? 16'd2 : clks_per_bit_i;
    assign w_last       = (r_cnt == r_period - 16'd1);

    assign tx_serial_o  = r_tx;
    assign tx_active_o  = (r_state != S_IDLE);
    assign tx_done_o    = (r_state == S_STOP) && w_last;

    // FIFO storage write; contents need no reset because the pointers gate validity.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= tx_byte_i;
    end

    // FIFO pointer update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // FSM and datapath registers; the line register drives the pin directly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_period <= 16'd2;
            r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_idx    <= w_idx_n;
            r_shift  <= w_shift_n;
            r_period <= w_period_n;
            r_tx     <= w_tx_n;
`ifdef UART_TX_PARITY_EN
            r_par    <= w_par_n;
`endif
        end
    end

    // Next-state logic; the line value is derived from the next state so it changes on the same edge.
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_idx_n    = r_idx;
        w_shift_n  = r_shift;
        w_period_n = r_period;
        w_pop      = 1'b0;
        w_load     = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_n    = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty) w_load = 1'b1;
            end
            S_START: begin
                if (w_last) begin
                    w_cnt_n   = '0;
                    w_idx_n   = '0;
                    w_state_n = S_DATA;
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (w_last) begin
                    w_cnt_n   = '0;
                    w_shift_n = {1'b0, r_shift[7:1]};
                    w_idx_n   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_n = S_PARITY;
`else
                        w_state_n = S_STOP;
`endif
                    end
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_last) begin
                    w_cnt_n   = '0;
                    w_state_n = S_STOP;
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (w_last) begin
                    w_cnt_n = '0;
                    if (!w_empty) w_load = 1'b1;
                    else          w_state_n = S_IDLE;
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        // Frame start from IDLE or straight out of a stop bit: pop, re-latch period.
        if (w_load) begin
            w_pop      = 1'b1;
            w_shift_n  = w_head;
            w_period_n = w_eff_period;
            w_cnt_n    = '0;
            w_state_n  = S_START;
`ifdef UART_TX_PARITY_EN
            w_par_n    = (^w_head) ^ parity_odd_i;
`endif
        end

        case (w_state_n)
            S_START:  w_tx_n = 1'b0;
            S_DATA:   w_tx_n = w_shift_n[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_n = w_par_n;
`endif
            default:  w_tx_n = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed bench with a scoreboard of expected frames decoded off the line.
`timescale 1ns/1ps
module tb_uart_transmitter;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] clks_per_bit_i = 16'd4;
    logic        tx_valid_i = 1'b0;
    logic [7:0]  tx_byte_i = 8'h00;
    logic        parity_odd_i = 1'b0;
    logic        tx_ready_o, tx_serial_o, tx_active_o, tx_done_o;
    logic [2:0]  fifo_level_o;

    typedef struct {
        logic [7:0] b;
        int         per;
        logic       par;
    } exp_t;

    exp_t sbq[$];
    int   n_asserts = 0, n_fail = 0;
    int   frames = 0, contig = 0, n_done = 0;
    time  last_end = 0, last_start = 0;

    always #5 clk_i = ~clk_i;

    uart_transmitter #(.FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clks_per_bit_i(clks_per_bit_i),
        .tx_valid_i(tx_valid_i), .tx_byte_i(tx_byte_i),
`ifdef UART_TX_PARITY_EN
        .parity_odd_i(parity_odd_i),
`endif
        .tx_ready_o(tx_ready_o), .tx_serial_o(tx_serial_o), .tx_active_o(tx_active_o),
        .tx_done_o(tx_done_o), .fifo_level_o(fifo_level_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count every done pulse seen on the falling clock edge.
    always @(negedge clk_i) if (tx_done_o === 1'b1) n_done++;

    // Monitor: decode each frame at mid-bit, compare with the scoreboard head.
    initial begin
        exp_t       e;
        logic [10:0] bits;
        logic       act_ok, done_ok, aborted;
        time        t0;
        int         p;
        forever begin
            @(negedge tx_serial_o);
            if (rst_ni) begin
                t0 = $time;
                n_asserts++;
                assert (sbq.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_frame observed=1 expected=0");
                end
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    p = e.per;
                    if (t0 == last_end) contig++;
                    last_start = t0;
                    bits = '0; act_ok = 1'b1; done_ok = 1'b1; aborted = 1'b0;
                    for (int k = 0; k < NB * p; k++) begin
                        @(negedge clk_i);
                        if (!rst_ni) begin aborted = 1'b1; break; end
                        if (k % p == p / 2) bits[k / p] = tx_serial_o;
                        if (tx_active_o !== 1'b1) act_ok = 1'b0;
                        if (tx_done_o !== (k == NB * p - 1)) done_ok = 1'b0;
                    end
                    if (!aborted) begin
                        chk("start_bit", {31'd0, bits[0]}, 32'd0);
                        chk("data_byte", {24'd0, bits[8:1]}, {24'd0, e.b});
`ifdef UART_TX_PARITY_EN
                        chk("parity_bit", {31'd0, bits[9]}, {31'd0, e.par});
`endif
                        chk("stop_bit", {31'd0, bits[NB-1]}, 32'd1);
                        chk("active_frame", {31'd0, act_ok}, 32'd1);
                        chk("done_last_cycle", {31'd0, done_ok}, 32'd1);
                        last_end = t0 + time'(NB * p * 10);
                        frames++;
                    end
                end
            end
        end
    end

    task automatic push(input logic [7:0] b, input int per, input logic par,
                        output time t, output int stall);
        @(negedge clk_i);
        tx_valid_i = 1'b1;
        tx_byte_i  = b;
        stall = 0;
        while (!tx_ready_o && stall < 2000) begin
            @(negedge clk_i);
            stall++;
        end
        @(posedge clk_i);
        t = $time;
        sbq.push_back('{b: b, per: per, par: par});
        #1 tx_valid_i = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 5000 && frames < target; i++) @(negedge clk_i);
        chk("frames_done", frames, target);
    endtask

    initial begin
        time  t_e0;
        int   stall, fr_save;
        logic [7:0] tbl [6];
        tbl = '{8'hA3, 8'h0F, 8'hFF, 8'h00, 8'h81, 8'h5A};

        // Reset values and idle line.
        repeat (3) @(negedge clk_i);
        chk("rst_serial", {31'd0, tx_serial_o}, 32'd1);
        chk("rst_ready", {31'd0, tx_ready_o}, 32'd1);
        chk("rst_level", {29'd0, fifo_level_o}, 32'd0);
        chk("rst_active", {31'd0, tx_active_o}, 32'd0);
        rst_ni = 1'b1;
        repeat (100) @(negedge clk_i);
        chk("idle_done_cnt", n_done, 0);
        chk("idle_serial", {31'd0, tx_serial_o}, 32'd1);
        chk("idle_frames", frames, 0);

        // Single byte: latency from acceptance to start bit, one done pulse.
        push(8'h55, 4, 1'b0, t_e0, stall);
        wait_frames(1);
        chk("first_latency", 32'(last_start - t_e0), 32'd10);
        chk("single_done_cnt", n_done, 1);

        // Back-to-back burst fills the FIFO; 6th byte stalls until a pop.
        clks_per_bit_i = 16'd3;
        contig = 0;
        for (int i = 0; i < 6; i++) begin
            push(tbl[i], 3, ^tbl[i], t_e0, stall);
            if (i == 4) begin
                chk("full_level", {29'd0, fifo_level_o}, 32'd4);
                chk("full_ready", {31'd0, tx_ready_o}, 32'd0);
            end
            if (i == 5) chk("sixth_stalled", {31'd0, stall > 0}, 32'd1);
        end
        wait_frames(7);
        chk("contiguous", contig, 5);

        // Period change mid-frame applies only to the next frame; clamp below 2.
        clks_per_bit_i = 16'd4;
        push(8'h96, 4, ^8'h96, t_e0, stall);
        push(8'h3C, 8, ^8'h3C, t_e0, stall);
        repeat (10) @(negedge clk_i);
        clks_per_bit_i = 16'd8;
        wait_frames(9);
        clks_per_bit_i = 16'd1;
        push(8'hC5, 2, ^8'hC5, t_e0, stall);
        wait_frames(10);
        clks_per_bit_i = 16'd0;
        push(8'h6B, 2, ^8'h6B, t_e0, stall);
        wait_frames(11);

`ifdef UART_TX_PARITY_EN
        clks_per_bit_i = 16'd4;
        parity_odd_i = 1'b0;
        push(8'h07, 4, 1'b1, t_e0, stall);
        wait_frames(12);
        parity_odd_i = 1'b1;
        push(8'h07, 4, 1'b0, t_e0, stall);
        repeat (3) @(negedge clk_i);
        parity_odd_i = 1'b0;
        wait_frames(13);
`endif

        // Reset during data bit 3 with two bytes queued.
        clks_per_bit_i = 16'd4;
        push(8'hE7, 4, 1'b0, t_e0, stall);
        push(8'h11, 4, 1'b0, t_e0, stall);
        push(8'h22, 4, 1'b0, t_e0, stall);
        chk("queued_level", {29'd0, fifo_level_o}, 32'd2);
        repeat (17) @(negedge clk_i);
        chk("pre_rst_active", {31'd0, tx_active_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("midrst_serial", {31'd0, tx_serial_o}, 32'd1);
        chk("midrst_level", {29'd0, fifo_level_o}, 32'd0);
        chk("midrst_active", {31'd0, tx_active_o}, 32'd0);
        sbq.delete();
        fr_save = frames;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (100) @(negedge clk_i);
        chk("post_rst_frames", frames, fr_save);
        chk("post_rst_serial", {31'd0, tx_serial_o}, 32'd1);
        chk("post_rst_ready", {31'd0, tx_ready_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
